// File: rtl/parking_controller.sv
// rtl/parking_controller.sv - parking gate controller: password check, slot occupancy, gate timing, lockout
// Optional feature macro: GATE_SENSOR_EN (adds car_sense_i, holds gate open while a car is present)
module parking_controller #(
    parameter int              NUM_SLOTS   = 10,
    parameter int              SLOT_W      = 4,
    parameter int              PASS_W      = 5,
    parameter logic [PASS_W-1:0] PASSWORD  = 5'b10011,
    parameter int              GATE_CYCLES = 50,
    parameter int              MAX_TRIES   = 3,
    parameter int              LOCK_CYCLES = 200
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 req_valid_i,
    input  logic                 req_exit_i,
    input  logic [SLOT_W-1:0]    req_slot_i,
    input  logic [PASS_W-1:0]    req_pass_i,
`ifdef GATE_SENSOR_EN
    input  logic                 car_sense_i,
`endif
    output logic                 req_ready_o,
    output logic                 err_pos_o,
    output logic                 err_pass_o,
    output logic                 err_lock_o,
    output logic                 dir_left_o,
    output logic                 dir_right_o,
    output logic                 gate_open_o,
    output logic [NUM_SLOTS-1:0] occupancy_o,
    output logic [SLOT_W-1:0]    free_count_o,
    output logic                 full_o
);

    localparam int TMR_MAX = (GATE_CYCLES > LOCK_CYCLES) ? GATE_CYCLES : LOCK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int FAIL_W  = $clog2(MAX_TRIES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_GATE   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  exit_q, exit_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [PASS_W-1:0]     pass_q, pass_d;
    logic                  ready_q, ready_d;
    logic                  err_pos_q, err_pos_d;
    logic                  err_pass_q, err_pass_d;
    logic                  err_lock_q, err_lock_d;
    logic                  dir_left_q, dir_left_d;
    logic                  dir_right_q, dir_right_d;
    logic                  gate_q, gate_d;
    logic [NUM_SLOTS-1:0]  occ_q, occ_d;
    logic [SLOT_W-1:0]     free_q, free_d;
    logic                  full_q, full_d;
    logic [FAIL_W-1:0]     fail_q, fail_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;

    logic                  in_range;
    logic [NUM_SLOTS-1:0]  slot_mask;
    logic                  slot_taken;
    logic                  hold_gate;

    // Out-of-range slots shift the mask to zero, so slot_taken is only trusted when in_range.
    assign in_range   = (slot_q != '0) && (slot_q <= SLOT_W'(NUM_SLOTS));
    assign slot_mask  = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << (slot_q - SLOT_W'(1));
    assign slot_taken = |(occ_q & slot_mask);

`ifdef GATE_SENSOR_EN
    assign hold_gate = car_sense_i;
`else
    assign hold_gate = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        exit_d      = exit_q;
        slot_d      = slot_q;
        pass_d      = pass_q;
        ready_d     = ready_q;
        err_pos_d   = 1'b0;
        err_pass_d  = 1'b0;
        err_lock_d  = err_lock_q;
        dir_left_d  = dir_left_q;
        dir_right_d = dir_right_q;
        gate_d      = gate_q;
        occ_d       = occ_q;
        free_d      = free_q;
        fail_d      = fail_q;
        tmr_d       = tmr_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    exit_d  = req_exit_i;
                    slot_d  = req_slot_i;
                    pass_d  = req_pass_i;
                    ready_d = 1'b0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
                if (pass_q != PASSWORD) begin
                    err_pass_d = 1'b1;
                    fail_d     = fail_q + FAIL_W'(1);
                    if (fail_q == FAIL_W'(MAX_TRIES - 1)) begin
                        err_lock_d = 1'b1;
                        tmr_d      = TMR_W'(LOCK_CYCLES - 1);
                        ready_d    = 1'b0;
                        state_d    = ST_LOCKED;
                    end
                end else begin
                    fail_d = '0;
                    if (!in_range || (slot_taken != exit_q)) begin
                        err_pos_d = 1'b1;
                    end else begin
                        gate_d  = 1'b1;
                        tmr_d   = TMR_W'(GATE_CYCLES - 1);
                        ready_d = 1'b0;
                        state_d = ST_GATE;
                        if (exit_q) begin
                            occ_d  = occ_q & ~slot_mask;
                            free_d = free_q + SLOT_W'(1);
                        end else begin
                            occ_d       = occ_q | slot_mask;
                            free_d      = free_q - SLOT_W'(1);
                            dir_left_d  = (slot_q <= SLOT_W'(NUM_SLOTS / 2));
                            dir_right_d = (slot_q >  SLOT_W'(NUM_SLOTS / 2));
                        end
                    end
                end
            end
            ST_GATE: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else if (!hold_gate) begin
                    gate_d      = 1'b0;
                    dir_left_d  = 1'b0;
                    dir_right_d = 1'b0;
                    ready_d     = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else begin
                    err_lock_d = 1'b0;
                    fail_d     = '0;
                    ready_d    = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        full_d = (free_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            exit_q      <= 1'b0;
            slot_q      <= '0;
            pass_q      <= '0;
            ready_q     <= 1'b1;
            err_pos_q   <= 1'b0;
            err_pass_q  <= 1'b0;
            err_lock_q  <= 1'b0;
            dir_left_q  <= 1'b0;
            dir_right_q <= 1'b0;
            gate_q      <= 1'b0;
            occ_q       <= '0;
            free_q      <= SLOT_W'(NUM_SLOTS);
            full_q      <= 1'b0;
            fail_q      <= '0;
            tmr_q       <= '0;
        end else begin
            state_q     <= state_d;
            exit_q      <= exit_d;
            slot_q      <= slot_d;
            pass_q      <= pass_d;
            ready_q     <= ready_d;
            err_pos_q   <= err_pos_d;
            err_pass_q  <= err_pass_d;
            err_lock_q  <= err_lock_d;
            dir_left_q  <= dir_left_d;
            dir_right_q <= dir_right_d;
            gate_q      <= gate_d;
            occ_q       <= occ_d;
            free_q      <= free_d;
            full_q      <= full_d;
            fail_q      <= fail_d;
            tmr_q       <= tmr_d;
        end
    end

    assign req_ready_o  = ready_q;
    assign err_pos_o    = err_pos_q;
    assign err_pass_o   = err_pass_q;
    assign err_lock_o   = err_lock_q;
    assign dir_left_o   = dir_left_q;
    assign dir_right_o  = dir_right_q;
    assign gate_open_o  = gate_q;
    assign occupancy_o  = occ_q;
    assign free_count_o = free_q;
    assign full_o       = full_q;

endmodule

// File: tb/tb_parking_controller.sv
// tb/tb_parking_controller.sv - directed self-checking bench for parking_controller
module tb_parking_controller;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_exit;
    logic [3:0] req_slot;
    logic [4:0] req_pass;
`ifdef GATE_SENSOR_EN
    logic       car_sense;
`endif
    logic       req_ready, err_pos, err_pass, err_lock;
    logic       dir_left, dir_right, gate_open, full;
    logic [9:0] occupancy;
    logic [3:0] free_count;

    int errors = 0;
    int checks = 0;
    int n;

    parking_controller dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req_valid_i  (req_valid),
        .req_exit_i   (req_exit),
        .req_slot_i   (req_slot),
        .req_pass_i   (req_pass),
`ifdef GATE_SENSOR_EN
        .car_sense_i  (car_sense),
`endif
        .req_ready_o  (req_ready),
        .err_pos_o    (err_pos),
        .err_pass_o   (err_pass),
        .err_lock_o   (err_lock),
        .dir_left_o   (dir_left),
        .dir_right_o  (dir_right),
        .gate_open_o  (gate_open),
        .occupancy_o  (occupancy),
        .free_count_o (free_count),
        .full_o       (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns 1 ns after the decision edge.
    task automatic send(input logic ex, input logic [3:0] slot, input logic [4:0] pass);
        @(negedge clk);
        req_valid = 1'b1;
        req_exit  = ex;
        req_slot  = slot;
        req_pass  = pass;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic count_gate(output int cnt);
        cnt = 0;
        while (gate_open === 1'b1 && cnt < 400) begin
            cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic count_lock(output int cnt);
        cnt = 0;
        while (err_lock === 1'b1 && cnt < 400) begin
            cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic grant_entry(input logic [3:0] slot, input logic [9:0] occ_exp);
        int c;
        send(1'b0, slot, 5'b10011);
        chk("fill_gate", gate_open, 1);
        chk("fill_occ", occupancy, occ_exp);
        count_gate(c);
        chk("fill_gate_len", c, 50);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_exit  = 1'b0;
        req_slot  = '0;
        req_pass  = '0;
`ifdef GATE_SENSOR_EN
        car_sense = 1'b0;
`endif
        #22;
        chk("rst_ready", req_ready, 1);
        chk("rst_occ", occupancy, 0);
        chk("rst_free", free_count, 10);
        chk("rst_full", full, 0);
        chk("rst_outs", {err_pos, err_pass, err_lock, dir_left, dir_right, gate_open}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // entry slot 7
        send(1'b0, 4'd7, 5'b10011);
        chk("e7_gate", gate_open, 1);
        chk("e7_dir", {dir_left, dir_right}, 2'b01);
        chk("e7_occ", occupancy, 10'h040);
        chk("e7_free", free_count, 9);
        chk("e7_errs", {err_pos, err_pass}, 0);
        chk("e7_ready", req_ready, 0);
        count_gate(n);
        chk("e7_gate_len", n, 50);
        chk("e7_dir_off", {dir_left, dir_right}, 0);
        chk("e7_ready_back", req_ready, 1);

        // slot 3 then duplicate entry
        grant_entry(4'd3, 10'h044);
        send(1'b0, 4'd3, 5'b10011);
        chk("dup3_err_pos", err_pos, 1);
        chk("dup3_gate", gate_open, 0);
        chk("dup3_occ", occupancy, 10'h044);
        chk("dup3_free", free_count, 8);
        @(posedge clk);
        #1;
        chk("dup3_pulse_end", err_pos, 0);

        // three bad passwords -> lockout
        send(1'b0, 4'd4, 5'b00000);
        chk("bad1_err_pass", err_pass, 1);
        chk("bad1_lock", err_lock, 0);
        chk("bad1_ready", req_ready, 1);
        send(1'b0, 4'd4, 5'b00000);
        chk("bad2_err_pass", err_pass, 1);
        chk("bad2_lock", err_lock, 0);
        send(1'b0, 4'd4, 5'b00000);
        chk("bad3_err_pass", err_pass, 1);
        chk("bad3_lock", err_lock, 1);
        chk("bad3_ready", req_ready, 0);
        req_valid = 1'b1;
        req_exit  = 1'b0;
        req_slot  = 4'd2;
        req_pass  = 5'b10011;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        chk("lock_ignore_gate", gate_open, 0);
        chk("lock_ignore_ready", req_ready, 0);
        chk("lock_ignore_occ", occupancy, 10'h044);
        count_lock(n);
        chk("lock_len_rest", n, 190);
        chk("lock_ready_back", req_ready, 1);

        send(1'b0, 4'd1, 5'b10011);
        chk("e1_gate", gate_open, 1);
        chk("e1_dir", {dir_left, dir_right}, 2'b10);
        chk("e1_occ", occupancy, 10'h045);
        count_gate(n);
        chk("e1_gate_len", n, 50);

        // a good password clears the failure count
        send(1'b0, 4'd4, 5'b00001);
        send(1'b0, 4'd4, 5'b00001);
        send(1'b1, 4'd0, 5'b10011);
        chk("clr_err_pos", err_pos, 1);
        chk("clr_err_pass", err_pass, 0);
        send(1'b0, 4'd4, 5'b00001);
        chk("clr_bad_err_pass", err_pass, 1);
        chk("clr_no_lock", err_lock, 0);
        chk("clr_ready", req_ready, 1);

        // fill the lot
        grant_entry(4'd2,  10'h047);
        grant_entry(4'd4,  10'h04F);
        grant_entry(4'd5,  10'h05F);
        grant_entry(4'd6,  10'h07F);
        grant_entry(4'd8,  10'h0FF);
        grant_entry(4'd9,  10'h1FF);
        grant_entry(4'd10, 10'h3FF);
        chk("full_flag", full, 1);
        chk("full_free", free_count, 0);
        send(1'b0, 4'd5, 5'b10011);
        chk("full_err_pos", err_pos, 1);
        chk("full_gate", gate_open, 0);
        chk("full_occ", occupancy, 10'h3FF);
        send(1'b1, 4'd5, 5'b10011);
        chk("x5_gate", gate_open, 1);
        chk("x5_dir", {dir_left, dir_right}, 0);
        chk("x5_occ", occupancy, 10'h3EF);
        chk("x5_free", free_count, 1);
        chk("x5_full", full, 0);
        count_gate(n);
        chk("x5_gate_len", n, 50);

        // slot range and empty-slot exits
        send(1'b1, 4'd0, 5'b10011);
        chk("x0_err_pos", err_pos, 1);
        send(1'b1, 4'd11, 5'b10011);
        chk("x11_err_pos", err_pos, 1);
        chk("x11_gate", gate_open, 0);
        send(1'b1, 4'd5, 5'b10011);
        chk("xfree_err_pos", err_pos, 1);
        chk("xfree_occ", occupancy, 10'h3EF);
        send(1'b0, 4'd15, 5'b10011);
        chk("e15_err_pos", err_pos, 1);
        chk("e15_free", free_count, 1);

`ifdef GATE_SENSOR_EN
        car_sense = 1'b1;
        send(1'b0, 4'd5, 5'b10011);
        repeat (60) begin
            @(posedge clk);
            #1;
        end
        chk("sense_hold", gate_open, 1);
        car_sense = 1'b0;
        @(posedge clk);
        #1;
        chk("sense_close", gate_open, 0);
        send(1'b1, 4'd5, 5'b10011);
        count_gate(n);
`endif

        // reset in the middle of a gate cycle
        send(1'b0, 4'd5, 5'b10011);
        chk("mid_gate", gate_open, 1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gate", gate_open, 0);
        chk("mid_rst_occ", occupancy, 0);
        chk("mid_rst_free", free_count, 10);
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_dir", {dir_left, dir_right}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
